// File: rtl/cus19_fetch_stage.sv
// Custom19 instruction fetch stage: owns the PC, reads a 1-cycle synchronous instruction memory
// and feeds a registered IF/ID interface, with a one-entry skid buffer to absorb decode stalls.
module cus19_fetch_stage #(
  parameter int unsigned              ADDR_W   = 11,
  parameter logic        [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [18:0]       imem_rdata,
  output logic [18:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_pend_q, req_pend_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [18:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [18:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;

  // A redirect always issues, even under stall; otherwise stall suppresses new requests so
  // at most one response can land in the skid buffer.
  always_comb begin
    imem_addr  = redirect_valid ? redirect_addr : pc_q;
    imem_rd_en = !rst && (redirect_valid || !stall);
  end

  always_comb begin
    pc_d         = pc_q;
    req_pend_d   = 1'b0;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;

    if (imem_rd_en) begin
      req_pend_d = 1'b1;
      req_pc_d   = imem_addr;
      pc_d       = imem_addr + 1'b1;
    end

    if (redirect_valid) begin
      // In-flight response and any skid entry belong to the wrong path.
      skid_valid_d = 1'b0;
      valid_d      = 1'b0;
    end else if (stall) begin
      if (req_pend_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc_d    = req_pc_q;
      end
    end else if (skid_valid_q) begin
      instr_d      = skid_instr_q;
      pc_out_d     = skid_pc_q;
      valid_d      = 1'b1;
      skid_valid_d = 1'b0;
    end else if (req_pend_q) begin
      instr_d  = imem_rdata;
      pc_out_d = req_pc_q;
      valid_d  = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      req_pend_q   <= 1'b0;
      req_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_pend_q   <= req_pend_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
    end
  end

  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_cus19_fetch_stage.sv
// Scoreboard bench for cus19_fetch_stage: stimulus queues expected PCs, a monitor pops one per
// newly presented instruction; memory word at address a is {8'h5A, a}.
module tb_cus19_fetch_stage;
  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          rst, stall, redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [18:0]   imem_rdata = '0;
  logic [18:0]   instr_out;
  logic [AW-1:0] pc_out;
  logic          instr_valid;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_q[$];
  logic          edge_live = 1'b0;

  cus19_fetch_stage #(.ADDR_W(AW), .RESET_PC(11'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mem_word(input logic [AW-1:0] a);
    return {8'h5A, a};
  endfunction

  // Garbage when no request was made, so consuming unrequested data is visible.
  always @(posedge clk) begin
    imem_rdata <= imem_rd_en ? mem_word(imem_addr) : 19'h7FFFF;
    edge_live  <= !rst && !stall;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: a new instruction is presented when the last edge was neither reset nor stall.
  always @(negedge clk) begin
    if (edge_live && instr_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got pc=%0h, none expected", pc_out);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        check("sb_pc", 32'(pc_out), 32'(e));
        check("sb_instr", 32'(instr_out), 32'(mem_word(e)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_req(input string name, input logic en, input logic [AW-1:0] addr);
    #1;
    check({name, "_rd_en"}, 32'(imem_rd_en), 32'(en));
    if (en) check({name, "_addr"}, 32'(imem_addr), 32'(addr));
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) exp_q.push_back(AW'(k));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    repeat (3) tick();
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_pc", 32'(pc_out), 0);
    check("rst_instr", 32'(instr_out), 0);
    check_req("rst_req", 1'b0, '0);

    // Cycle 0: first request to RESET_PC.
    push_range(0, 5);
    rst = 1'b0;
    check_req("c0", 1'b1, 11'd0);
    tick();  // cycle 1
    check("c1_valid", 32'(instr_valid), 0);
    check_req("c1", 1'b1, 11'd1);
    tick();  // cycle 2
    check("c2_valid", 32'(instr_valid), 1);
    repeat (5) tick();  // cycle 7, pc_out = 5

    // Stall cycles 7..9; word 6 lands in skid.
    check("pre_stall_pc", 32'(pc_out), 5);
    push_range(6, 10);
    stall = 1'b1;
    check_req("stall0", 1'b0, '0);
    repeat (2) begin
      tick();
      check("stall_hold_pc", 32'(pc_out), 5);
      check("stall_hold_instr", 32'(instr_out), 32'(mem_word(11'd5)));
      check("stall_hold_valid", 32'(instr_valid), 1);
      check_req("stall_n", 1'b0, '0);
    end
    tick();  // cycle 10: release
    check("stall_hold_pc3", 32'(pc_out), 5);
    stall = 1'b0;
    check_req("release", 1'b1, 11'd7);
    repeat (5) tick();  // cycle 15, pc_out = 10

    // Redirect to 0x100; word 11 dropped.
    push_range(32'h100, 32'h102);
    redirect_valid = 1'b1; redirect_addr = 11'h100;
    check_req("redir", 1'b1, 11'h100);
    tick();  // cycle 16
    redirect_valid = 1'b0;
    check("redir_bubble", 32'(instr_valid), 0);
    check_req("post_redir", 1'b1, 11'h101);
    repeat (3) tick();  // cycle 19, pc_out = 0x102

    // Stall fills skid with 0x103, then redirect under stall discards it.
    stall = 1'b1;
    tick();  // cycle 20
    check("skid_hold_pc", 32'(pc_out), 32'h102);
    push_range(32'h040, 32'h042);
    redirect_valid = 1'b1; redirect_addr = 11'h040;
    check_req("stall_redir", 1'b1, 11'h040);
    tick();  // cycle 21
    redirect_valid = 1'b0; stall = 1'b0;
    check("stall_redir_bubble", 32'(instr_valid), 0);
    repeat (3) tick();  // cycle 24, pc_out = 0x042

    // Redirect near the top of the address space: wraps 0x7FF -> 0x000.
    push_range(32'h7FE, 32'h7FF);
    push_range(0, 20);
    redirect_valid = 1'b1; redirect_addr = 11'h7FE;
    tick();  // cycle 25
    redirect_valid = 1'b0;
    check("wrap_bubble", 32'(instr_valid), 0);
    repeat (23) tick();  // cycle 48, pc_out = 20

    // One-cycle reset mid-stream.
    check("pre_rst_pc", 32'(pc_out), 20);
    push_range(0, 4);
    rst = 1'b1;
    check_req("mid_rst", 1'b0, '0);
    tick();  // cycle 49
    rst = 1'b0;
    check("mid_rst_valid", 32'(instr_valid), 0);
    check("mid_rst_pc", 32'(pc_out), 0);
    check("mid_rst_instr", 32'(instr_out), 0);
    check_req("restart", 1'b1, 11'd0);
    repeat (6) tick();  // cycle 55, pc_out = 4
    stall = 1'b1;
    tick();
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cus19_fetch_stage.md
# cus19_fetch_stage

Instruction fetch stage of the Custom19 processor, directly upstream of the instruction decoder. It owns the program counter, issues word reads to a synchronous instruction memory (one-cycle read latency), and presents each fetched 19-bit instruction word and its PC to the decoder through a registered IF/ID interface. It supports stall (back-pressure from decode), redirect (taken branch/jump), and a one-entry skid buffer so no memory response is lost.

## Interface
- ADDR_W, 11, instruction word address width; matches the 11-bit imm/addr field.
- RESET_PC, 0, first fetch address after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decoder cannot accept; IF/ID outputs must hold.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_addr  in  ADDR_W  target word address.
- imem_rd_en  out  1  read request this cycle (combinational).
- imem_addr  out  ADDR_W  read address (combinational).
- imem_rdata  in  19  read data, valid the cycle after an accepted request.
- instr_out  out  19  instruction word to decoder (registered).
- pc_out  out  ADDR_W  address of instr_out (registered).
- instr_valid  out  1  instr_out/pc_out hold a live instruction.

## Operation
- State: pc (next sequential address), req_pend and req_pc (request issued last cycle), skid_valid/skid_instr/skid_pc, IF/ID output registers.
- Priority every cycle: rst > redirect_valid > stall > normal.
- Reset (rst=1): pc<=RESET_PC; req_pend, skid_valid, instr_valid <=0; instr_out, pc_out <=0; imem_rd_en=0 during rst.
- imem_addr = redirect_valid ? redirect_addr : pc. imem_rd_en = !rst && (redirect_valid || !stall).
- On issued request: req_pend<=1, req_pc<=imem_addr, pc<=imem_addr+1 (mod 2^ADDR_W; 2047 wraps to 0). No request: req_pend<=0, pc holds.
- Normal (!stall, !redirect): if skid_valid, IF/ID <= skid contents, skid_valid<=0; else if req_pend, IF/ID <= {imem_rdata, req_pc}, instr_valid<=1; else instr_valid<=0.
- Stall (!redirect): IF/ID holds unchanged; if req_pend, response captured into skid {imem_rdata, req_pc}, skid_valid<=1. Skid never overflows: no request is issued while stalled, so at most one response arrives.
- Redirect (with or without stall): in-flight response discarded; skid_valid<=0; instr_valid<=0; request issued to redirect_addr; pc<=redirect_addr+1.
- instr_out contents when instr_valid=0 are don't-care to the decoder but must not change while stall=1.

## Timing
- First request: first cycle with rst=0, imem_addr=RESET_PC. instr_valid first rises 2 cycles after rst falls (request N, data N+1, registered visible N+2).
- Steady state: one instruction per cycle, fetch-to-IF/ID latency 2 cycles.
- Redirect penalty: 1 bubble cycle (instr_valid=0) then target instruction; target visible 2 cycles after redirect cycle.
- Stall release: held skid entry appears the cycle after release; new request issued in release cycle, its data lands the following cycle, so no bubble when skid was full.
- Reset asserted mid-stream or mid-stall: outputs reach reset values at next edge; pending response and skid discarded.

## Test plan
- Reset with RESET_PC=0, memory word k = k: rst falls at cycle 0 -> imem_addr 0,1,2,... per cycle; instr_valid high from cycle 2 with instr_out/pc_out = 0,1,2,... one per cycle.
- Stall 3 cycles while instr_out=5: outputs hold 5, imem_rd_en=0, skid captures 6 -> after release instr_out=6,7,8 consecutive, no gaps or duplicates.
- redirect_valid with redirect_addr=0x100 while pc_out=10: next cycle instr_valid=0 (word 11 dropped), then instr_out=0x100, pc_out=0x100, then 0x101.
- Redirect asserted during stall with skid full: skid cleared, instr_valid=0 next cycle, then target 0x040 delivered; stale skid word never appears.
- Redirect to 0x7FE: pc_out sequence 0x7FE, 0x7FF, 0x000 (wrap).
- rst pulsed for 1 cycle mid-stream at pc_out=20: instr_valid=0, pc_out=0, instr_out=0 next edge; fetch restarts from RESET_PC.
